// File: rtl/sram_ctrl_pkg.sv
// Shared constants and types for the 256x80 SRAM port controller.
// Optional zero-fill sweep after reset: define SRAM_CTRL_INIT_SWEEP_EN.
package sram_ctrl_pkg;
  localparam int SRAM_DATA_W    = 80;
  localparam int SRAM_DEPTH     = 256;
  localparam int SRAM_ADDR_W    = 8;
  localparam int RESP_BUF_DEPTH = 2;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } ctrl_state_e;
endpackage

// File: rtl/sram_resp_buf.sv
// Two-entry read-response FIFO between the SRAM macro and the consumer.
// Head entry drives rdata_o; a pop on an empty buffer is ignored.
module sram_resp_buf
  import sram_ctrl_pkg::*;
#(
  parameter int W = SRAM_DATA_W
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         valid_o,
  output logic [1:0]   count_o
);
  logic [W-1:0] mem_q [RESP_BUF_DEPTH];
  logic         wr_ptr_q;
  logic         rd_ptr_q;
  logic [1:0]   cnt_q;
  logic [1:0]   cnt_d;
  logic         pop;

  assign valid_o = (cnt_q != 2'd0);
  assign pop     = pop_i && valid_o;
  assign cnt_d   = cnt_q + {1'b0, push_i} - {1'b0, pop};

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) wr_ptr_q <= !wr_ptr_q;
      if (pop)    rd_ptr_q <= !rd_ptr_q;
      cnt_q <= cnt_d;
    end
  end

  // Storage needs no reset; valid_o masks stale entries.
  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = cnt_q;

  a_no_overflow: assert property (
    @(posedge clock) disable iff (reset)
    push_i |-> (cnt_q != 2'(RESP_BUF_DEPTH))
  );
endmodule

// File: rtl/sram_port_ctrl_256x80.sv
// Valid/ready front end for the 256x80 single-port SRAM macro.
// Define SRAM_CTRL_INIT_SWEEP_EN to zero-fill the array after reset.
module sram_port_ctrl_256x80
  import sram_ctrl_pkg::*;
#(
  parameter int DATA_W = SRAM_DATA_W,
  parameter int DEPTH  = SRAM_DEPTH,
  parameter int ADDR_W = SRAM_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              init_done,
  output logic              sram_ceb,
  output logic              sram_web,
  output logic [ADDR_W-1:0] sram_a,
  output logic [DATA_W-1:0] sram_d,
  input  logic [DATA_W-1:0] sram_q
);
  if (DEPTH != (1 << ADDR_W)) begin : g_cfg_err
    $error("DEPTH must equal 2**ADDR_W");
  end

  ctrl_state_e state_q, state_d;
  logic        done_q, done_d;
  logic        rd_inf_q;
  logic [1:0]  out_cnt;
  logic [2:0]  occ;
  logic        deq;
  logic        credit_ok;
  logic        fire;
  logic        rd_fire;

`ifdef SRAM_CTRL_INIT_SWEEP_EN
  localparam ctrl_state_e       RST_ST = ST_INIT;
  localparam logic [ADDR_W-1:0] LAST   = ADDR_W'(DEPTH - 1);
  logic [ADDR_W-1:0] swp_q, swp_d;
`else
  localparam ctrl_state_e RST_ST = ST_RUN;
`endif

  // Reads need a free slot counting buffered, in-flight and leaving data.
  assign deq       = resp_valid && resp_ready;
  assign occ       = {1'b0, out_cnt} + {2'b0, rd_inf_q} - {2'b0, deq};
  assign credit_ok = (occ < 3'd2);
  assign req_ready = done_q && (req_write || credit_ok);
  assign fire      = req_valid && req_ready;
  assign rd_fire   = fire && !req_write;
  assign init_done = done_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= RST_ST;
      done_q   <= 1'b0;
      rd_inf_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      done_q   <= done_d;
      rd_inf_q <= rd_fire;
    end
  end

`ifdef SRAM_CTRL_INIT_SWEEP_EN
  always_ff @(posedge clock) begin
    if (reset) swp_q <= '0;
    else       swp_q <= swp_d;
  end
`endif

  always_comb begin
    state_d  = state_q;
    sram_ceb = 1'b1;
    sram_web = 1'b1;
    sram_a   = '0;
    sram_d   = '0;
`ifdef SRAM_CTRL_INIT_SWEEP_EN
    swp_d    = swp_q;
`endif
    unique case (state_q)
      ST_INIT: begin
`ifdef SRAM_CTRL_INIT_SWEEP_EN
        swp_d = swp_q + ADDR_W'(1);
        // Keep the macro idle while reset is still held.
        if (!reset) begin
          sram_ceb = 1'b0;
          sram_web = 1'b0;
          sram_a   = swp_q;
        end
        if (swp_q == LAST) state_d = ST_RUN;
`else
        state_d = ST_RUN;
`endif
      end
      ST_RUN: begin
        if (fire) begin
          sram_ceb = 1'b0;
          sram_web = !req_write;
          sram_a   = req_addr;
          if (req_write) sram_d = req_wdata;
        end
      end
      default: ;
    endcase
    done_d = (state_d == ST_RUN);
  end

  sram_resp_buf #(
    .W (DATA_W)
  ) u_buf (
    .clock   (clock),
    .reset   (reset),
    .push_i  (rd_inf_q),
    .pop_i   (deq),
    .wdata_i (sram_q),
    .rdata_o (resp_rdata),
    .valid_o (resp_valid),
    .count_o (out_cnt)
  );
endmodule

// File: tb/tb_sram_port_ctrl_256x80.sv
// Scoreboard bench for sram_port_ctrl_256x80 with a behavioural macro.
// Honours SRAM_CTRL_INIT_SWEEP_EN when the design is built with it.
module tb_sram_port_ctrl_256x80;
  localparam int DW = 80;
  localparam int AW = 8;
  localparam int N  = 256;
  localparam logic [DW-1:0] A5 = {10{8'hA5}};
  localparam logic [DW-1:0] C3 = {10{8'hC3}};

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic [DW-1:0] resp_rdata;
  logic          init_done;
  logic          sram_ceb;
  logic          sram_web;
  logic [AW-1:0] sram_a;
  logic [DW-1:0] sram_d;
  logic [DW-1:0] sram_q;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  sram_port_ctrl_256x80 dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .init_done  (init_done),
    .sram_ceb   (sram_ceb),
    .sram_web   (sram_web),
    .sram_a     (sram_a),
    .sram_d     (sram_d),
    .sram_q     (sram_q)
  );

  // Macro model: Q is only meaningful the cycle after a read.
  logic [DW-1:0] mem [N];
  logic [DW-1:0] q_r;
  always @(posedge clock) begin
    if (!sram_ceb && !sram_web) mem[sram_a] <= sram_d;
    q_r <= (!sram_ceb && sram_web) ? mem[sram_a] : {20{4'hD}};
  end
  assign sram_q = q_r;

  function automatic logic [DW-1:0] pat(input int i);
    logic [7:0] b;
    b = 8'(i) ^ 8'h5A;
    return {10{b}};
  endfunction

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: expectations pushed at request fire, popped at response.
  logic [DW-1:0] ref_mem [N];
  logic [DW-1:0] exp_q [$];
  always @(negedge clock) begin
    if (reset) begin
      exp_q.delete();
      for (int i = 0; i < N; i++) ref_mem[i] = '0;
    end else begin
      if (req_valid && req_ready) begin
        if (req_write) ref_mem[req_addr] = req_wdata;
        else exp_q.push_back(ref_mem[req_addr]);
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) chk("resp_unexpected", 1, 0);
        else chk("resp_data", resp_rdata, exp_q.pop_front());
      end
    end
  end

  task automatic idle();
    req_valid = 1'b0;
    req_write = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic issue(input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    int t;
    t = 0;
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    @(negedge clock);
    while (!req_ready && t < 50) begin
      t++;
      @(negedge clock);
    end
    chk("req_accept", req_ready, 1);
    tick();
    idle();
  endtask

  task automatic stream(input logic w, input int base, input int n,
                        input bit chk_resp);
    for (int i = 0; i < n; i++) begin
      req_valid = 1'b1;
      req_write = w;
      req_addr  = AW'(base + i);
      req_wdata = w ? pat(base + i) : '0;
      @(negedge clock);
      chk("stream_ready", req_ready, 1);
      if (chk_resp && i >= 2) begin
        chk("stream_valid", resp_valid, 1);
        chk("stream_order", resp_rdata, pat(base + i - 2));
      end
      tick();
    end
    idle();
  endtask

  task automatic wait_init();
`ifdef SRAM_CTRL_INIT_SWEEP_EN
    for (int i = 0; i < N; i++) begin
      @(negedge clock);
      chk("sweep_strobe",
          {sram_ceb, sram_web, sram_a, sram_d, init_done, req_ready},
          {1'b0, 1'b0, AW'(i), 80'h0, 1'b0, 1'b0});
    end
    @(negedge clock);
    chk("init_done_rise", init_done, 1);
    tick();
`else
    int n;
    n = 0;
    while (!init_done && n < 8) begin
      tick();
      n++;
    end
    chk("init_done_lat", n, 1);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle();
    tick();
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_ceb", sram_ceb, 1);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_init_done", init_done, 0);
    chk("rst_web_a_d", {sram_web, sram_a, sram_d}, {1'b1, 8'h0, 80'h0});
    tick();
    reset = 1'b0;
    wait_init();
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    resp_ready = 1'b1;

`ifdef SRAM_CTRL_INIT_SWEEP_EN
    issue(1'b0, 8'h00, '0);
    issue(1'b0, 8'h80, '0);
    issue(1'b0, 8'hFF, '0);
    tick();
    tick();
    chk("sweep_zero_drained", exp_q.size(), 0);
`endif

    // Write then read next cycle, with exact latency.
    issue(1'b1, 8'h10, A5);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h10;
    @(negedge clock);
    chk("raw_ready", req_ready, 1);
    tick();
    idle();
    @(negedge clock);
    chk("lat_t1_valid", resp_valid, 0);
    @(negedge clock);
    chk("lat_t2_valid", resp_valid, 1);
    chk("lat_t2_data", resp_rdata, A5);
    tick();

    // Fill the array, then stream every address back.
    stream(1'b1, 0, N, 1'b0);
    stream(1'b0, 0, N, 1'b1);
    repeat (3) tick();

    // Backpressure: two reads outstanding, third stalls, write passes.
    resp_ready = 1'b0;
    issue(1'b0, 8'h20, '0);
    issue(1'b0, 8'h21, '0);
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 8'h22;
    @(negedge clock);
    chk("bp_stall_1", req_ready, 0);
    tick();
    @(negedge clock);
    chk("bp_stall_2", req_ready, 0);
    chk("bp_head", {resp_valid, resp_rdata}, {1'b1, pat(8'h20)});
    tick();
    req_write = 1'b1;
    req_wdata = C3;
    @(negedge clock);
    chk("bp_write_ok", req_ready, 1);
    tick();
    idle();
    resp_ready = 1'b1;
    issue(1'b0, 8'h22, '0);
    issue(1'b0, 8'h23, '0);
    repeat (4) tick();
    chk("bp_drained", exp_q.size(), 0);

    // Steady push+pop keeps one entry buffered and accepts every read.
    stream(1'b0, 8'h30, 4, 1'b1);
    repeat (3) tick();

    // Reset while two responses are pending.
    resp_ready = 1'b0;
    issue(1'b0, 8'h40, '0);
    issue(1'b0, 8'h41, '0);
    tick();
    chk("pend_head", {resp_valid, resp_rdata}, {1'b1, pat(8'h40)});
    do_reset();
    resp_ready = 1'b1;
    issue(1'b1, 8'h50, A5);
    issue(1'b0, 8'h50, '0);
`ifdef SRAM_CTRL_INIT_SWEEP_EN
    issue(1'b0, 8'h40, '0);
`endif
    repeat (4) tick();
    chk("final_drained", exp_q.size(), 0);
    chk("final_idle", {resp_valid, sram_ceb}, {1'b0, 1'b1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
